uc_rr_arbiter: RTL
==================

UC_RR_ARBITER -- requirements
Module: uc_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_ENGINE, default 4, number of engine unit-clause queues arbitrated.
REQ-002 SHALL have parameter LIT_W, default 8, signed literal width; variable index = |lit|, NUM_VARS = 2^(LIT_W-1)-1.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, output broadcast FIFO entries.
REQ-004 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: clear  in  1  synchronous epoch clear.
REQ-007 SHALL have ports: mem_valid in 1, mem_lit in LIT_W (signed), mem_done in 1, mem_ready out 1; memory unit-clause load stream.
REQ-008 SHALL have ports: eng_lit in NUM_ENGINE*LIT_W, eng_valid in NUM_ENGINE, eng_empty in NUM_ENGINE, eng_pop out NUM_ENGINE (one-hot or zero).
REQ-009 SHALL have port: eng_full  in  NUM_ENGINE  engine broadcast queues full.
REQ-010 SHALL have ports: out_valid out 1, out_lit out LIT_W (signed); broadcast to all engines.
REQ-011 SHALL have ports: conflict out 1, conflict_lit out LIT_W, state out 2.

Function
REQ-012 SHALL implement FSM IDLE(0), LOAD(1), RUN(2), CONFLICT(3): IDLE->LOAD on mem_valid; LOAD->RUN on mem_done (mem_done with mem_valid: literal accepted, then RUN); RUN->CONFLICT on detected conflict; any state->IDLE on clear.
REQ-013 SHALL assert mem_ready = (state IDLE or LOAD) and FIFO not full; memory literal accepted when mem_valid & mem_ready.
REQ-014 SHALL, in RUN only, grant round-robin among engines with !eng_empty & eng_valid when FIFO not full, asserting eng_pop[g] combinationally that cycle; priority pointer moves to g+1 mod NUM_ENGINE after each grant.
REQ-015 SHALL pop an engine with !eng_empty & !eng_valid without accepting its literal (bubble discard); pointer advances as for a grant.
REQ-016 SHALL keep a per-variable table {assigned, polarity} of NUM_VARS entries; accepted literal checked combinationally against registered table.
REQ-017 SHALL on accepted literal: lit==0 -> drop; variable unassigned -> set entry, push FIFO; same polarity -> drop (no push); opposite polarity -> conflict.
REQ-018 SHALL on conflict register conflict=1 and conflict_lit=offending literal next cycle, enter CONFLICT, stop all pops and mem_ready, flush FIFO, hold until clear.
REQ-019 SHALL assert out_valid when FIFO non-empty, state != CONFLICT, and eng_full == 0; FIFO pops that cycle; out_lit = FIFO head.
REQ-020 SHALL give latency: literal accepted cycle N -> out_valid earliest cycle N+1; sustained throughput 1 literal/cycle.
REQ-021 SHALL support simultaneous FIFO push and pop when full (pop frees slot only next cycle; mem_ready/grant use registered full).
REQ-022 SHALL give clear priority over every same-cycle event: table zeroed, FIFO emptied, conflict deasserted, state IDLE next cycle, no pop that cycle.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-024 SHALL on rst low immediately set: state IDLE, table zeroed, FIFO empty, RR pointer 0, conflict 0, conflict_lit 0, out_valid 0, eng_pop 0, mem_ready 1 after release.
REQ-025 SHALL, on reset mid-operation, discard all in-flight literals with no pop or output in the reset cycle.

Structure
REQ-026 SHALL place literal typedef, FSM state enum and default parameter constants in shared package uc_pkg.
REQ-027 SHALL instantiate one sub-module uc_fifo (parametrised width/depth, sync flush); RR grant logic inline.

Verification
REQ-028 SHALL cover: load mem literals 3,-5,7 then mem_done -> out_lit 3,-5,7 on consecutive cycles, state RUN.
REQ-029 SHALL cover: 4 engines all non-empty, pointer 0 -> eng_pop 0001,0010,0100,1000,0001 on successive cycles.
REQ-030 SHALL cover: engine 1 supplies 5 after mem loaded -5 -> conflict=1, conflict_lit=5 next cycle, state CONFLICT, eng_pop 0.
REQ-031 SHALL cover: duplicate 7 from engines 0 and 2 -> exactly one out_lit 7.
REQ-032 SHALL cover: eng_full[3]=1 with FIFO_DEPTH literals accepted -> out_valid 0, mem_ready 0, no pops; release -> drain in order.
REQ-033 SHALL cover: clear asserted same cycle as conflicting literal -> conflict stays 0, state IDLE, FIFO empty.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared types and default sizing for the unit-clause round-robin arbiter.
package uc_pkg;

  localparam int DEF_NUM_ENGINE = 4;
  localparam int DEF_LIT_W      = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  // Signed literal at the default width; sign is polarity, magnitude is the variable.
  typedef logic signed [DEF_LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RUN      = 2'd2,
    ST_CONFLICT = 2'd3
  } state_e;

endpackage

// File: rtl/uc_rr_arbiter_if.sv
// Bus bundle between the arbiter, the clause memory, the engines and the broadcast sink.
interface uc_rr_arbiter_if #(
  parameter int NUM_ENGINE = 4,
  parameter int LIT_W      = 8
);
  // memory unit-clause load stream
  logic                                 mem_valid;
  logic signed [LIT_W-1:0]              mem_lit;
  logic                                 mem_done;
  logic                                 mem_ready;
  // engine unit-clause queues
  logic [NUM_ENGINE-1:0][LIT_W-1:0]     eng_lit;
  logic [NUM_ENGINE-1:0]                eng_valid;
  logic [NUM_ENGINE-1:0]                eng_empty;
  logic [NUM_ENGINE-1:0]                eng_pop;
  logic [NUM_ENGINE-1:0]                eng_full;
  // broadcast and status
  logic                                 out_valid;
  logic signed [LIT_W-1:0]              out_lit;
  logic                                 conflict;
  logic signed [LIT_W-1:0]              conflict_lit;
  logic [1:0]                           state;

  // arbiter side
  modport master (
    input  mem_valid, mem_lit, mem_done, eng_lit, eng_valid, eng_empty, eng_full,
    output mem_ready, eng_pop, out_valid, out_lit, conflict, conflict_lit, state
  );

  // environment side (memory, engines, broadcast consumers)
  modport slave (
    output mem_valid, mem_lit, mem_done, eng_lit, eng_valid, eng_empty, eng_full,
    input  mem_ready, eng_pop, out_valid, out_lit, conflict, conflict_lit, state
  );
endinterface

// File: rtl/uc_fifo.sv
// Broadcast FIFO: power-of-two depth, wrap-bit pointers, synchronous flush.
module uc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer update; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uc_rr_arbiter.sv
// Unit-clause arbiter: merges memory load stream and engine queues, dedups
// literals against a per-variable assignment table, detects conflicts and
// broadcasts newly assigned literals through a FIFO.
module uc_rr_arbiter
  import uc_pkg::*;
#(
  parameter int NUM_ENGINE = DEF_NUM_ENGINE,
  parameter int LIT_W      = DEF_LIT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  uc_rr_arbiter_if.master   bus
);
  localparam int NUM_VARS = 2**(LIT_W-1) - 1;
  localparam int RR_W     = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  state_e                   state_q, state_d;
  logic [NUM_VARS:0]        asg_q, asg_d;   // entry 0 unused
  logic [NUM_VARS:0]        pol_q, pol_d;   // 1 = negative polarity
  logic [RR_W-1:0]          rr_q, rr_d;
  logic                     conflict_q, conflict_d;
  logic signed [LIT_W-1:0]  clit_q, clit_d;

  logic                     f_full, f_empty, f_push, f_pop, f_flush;
  logic [LIT_W-1:0]         f_dout;

  logic                     mem_ready, mem_acc, arb_en;
  logic                     gnt_vld;
  logic [RR_W-1:0]          gnt_idx;
  logic [NUM_ENGINE-1:0]    pop_oh;
  logic                     acc_vld, neg, in_range, new_asg, is_conf;
  logic signed [LIT_W-1:0]  acc_lit;
  logic [LIT_W-1:0]         mag;
  logic [LIT_W-2:0]         vidx;
  int                       j;

  // Memory handshake uses registered full, so a same-cycle FIFO pop never frees a slot early.
  assign mem_ready = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !f_full;
  assign mem_acc   = bus.mem_valid && mem_ready && !clear;
  assign arb_en    = (state_q == ST_RUN) && !f_full && !clear;

  // Round-robin search for the first non-empty engine starting at the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_ENGINE; k++) begin
      j = (int'(rr_q) + k) % NUM_ENGINE;
      if (!gnt_vld && !bus.eng_empty[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = j[RR_W-1:0];
      end
    end
  end

  // Pop the winner (valid literal or bubble) and advance the pointer past it.
  always_comb begin
    pop_oh = '0;
    rr_d   = rr_q;
    if (arb_en && gnt_vld) begin
      pop_oh[gnt_idx] = 1'b1;
      rr_d = (gnt_idx == RR_W'(NUM_ENGINE-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Select the accepted literal and classify it against the registered table.
  always_comb begin
    acc_vld  = mem_acc || (arb_en && gnt_vld && bus.eng_valid[gnt_idx]);
    acc_lit  = mem_acc ? bus.mem_lit : bus.eng_lit[gnt_idx];
    neg      = acc_lit[LIT_W-1];
    mag      = neg ? LIT_W'(-acc_lit) : LIT_W'(acc_lit);
    // zero and the most-negative code have no variable and are dropped
    in_range = (mag != '0) && (mag <= LIT_W'(NUM_VARS));
    vidx     = mag[LIT_W-2:0];
    new_asg  = acc_vld && in_range && !asg_q[vidx];
    is_conf  = acc_vld && in_range && asg_q[vidx] && (pol_q[vidx] != neg);
  end

  // Next-state: clear dominates everything, conflict dominates push and state moves.
  always_comb begin
    state_d    = state_q;
    asg_d      = asg_q;
    pol_d      = pol_q;
    conflict_d = conflict_q;
    clit_d     = clit_q;
    f_push     = 1'b0;
    f_flush    = 1'b0;
    if (clear) begin
      state_d    = ST_IDLE;
      asg_d      = '0;
      pol_d      = '0;
      conflict_d = 1'b0;
      clit_d     = '0;
      f_flush    = 1'b1;
    end else begin
      if (new_asg) begin
        asg_d[vidx] = 1'b1;
        pol_d[vidx] = neg;
        f_push      = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: if (bus.mem_valid) state_d = bus.mem_done ? ST_RUN : ST_LOAD;
        ST_LOAD: if (bus.mem_done)  state_d = ST_RUN;
        default: ;
      endcase
      if (is_conf) begin
        state_d    = ST_CONFLICT;
        conflict_d = 1'b1;
        clit_d     = acc_lit;
        f_flush    = 1'b1;
      end
    end
  end

  // Broadcast only while every engine queue has room and no conflict is latched.
  assign f_pop = !f_empty && (state_q != ST_CONFLICT) && !(|bus.eng_full) && !clear;

  // State, table, pointer and conflict registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      asg_q      <= '0;
      pol_q      <= '0;
      rr_q       <= '0;
      conflict_q <= 1'b0;
      clit_q     <= '0;
    end else begin
      state_q    <= state_d;
      asg_q      <= asg_d;
      pol_q      <= pol_d;
      rr_q       <= rr_d;
      conflict_q <= conflict_d;
      clit_q     <= clit_d;
    end
  end

  uc_fifo #(
    .W     (LIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (f_flush),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (acc_lit),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign bus.mem_ready    = mem_ready;
  assign bus.eng_pop      = pop_oh;
  assign bus.out_valid    = f_pop;
  assign bus.out_lit      = f_dout;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_lit = clit_q;
  assign bus.state        = state_q;

endmodule
